// File: rtl/mpsk_mod_if.sv
// rtl/mpsk_mod_if.sv - bit-serial valid/ready input stream of the M-PSK modulator
interface mpsk_mod_if;
   logic x;
   logic x_valid;
   logic x_ready;

   modport master (output x, output x_valid, input x_ready);
   modport slave  (input x, input x_valid, output x_ready);
endinterface

// File: rtl/mpsk_mod.sv
// rtl/mpsk_mod.sv - M-ary PSK square-wave modulator: BPS serial bits per symbol, 1-bit carrier out
// Define MPSK_GRAY_EN to treat each symbol as Gray code when selecting the carrier phase.
module mpsk_mod #(
   parameter int BPS = 2,
   parameter int SPC = 8,
   parameter int CPS = 1
) (
   input  logic      clk,
   input  logic      reset,
   mpsk_mod_if.slave s_in,
   output logic      y,
   output logic      sym_start,
   output logic      underrun
);
   localparam int PW = $clog2(SPC);
   localparam int NW = $clog2(BPS + 1);
   localparam int CW = 8;
   localparam logic [PW-1:0] PH_LAST  = PW'(SPC - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(SPC / 2);
   localparam logic [CW-1:0] CYC_LAST = CW'(CPS - 1);
   localparam logic [NW-1:0] N_FULL   = NW'(BPS);

   function automatic logic [BPS-1:0] map_sym(input logic [BPS-1:0] s);
`ifdef MPSK_GRAY_EN
      logic [BPS-1:0] b;
      b[BPS-1] = s[BPS-1];
      for (int i = BPS - 2; i >= 0; i--) b[i] = b[i+1] ^ s[i];
      return b;
`else
      return s;
`endif
   endfunction

   logic [PW-1:0]  r_ph;
   logic [CW-1:0]  r_cyc;
   logic [BPS-1:0] r_col;
   logic [BPS-1:0] r_sym;
   logic [NW-1:0]  r_n;
   logic           r_active;
   logic           r_y;
   logic           r_sym_start;
   logic           r_underrun;

   logic           w_full;
   logic           w_xfer;
   logic           w_boundary;
   logic           w_load;
   logic           w_active_nxt;
   logic           w_c;
   logic [PW-1:0]  w_ph_nxt;
   logic [PW-1:0]  w_off;
   logic [PW-1:0]  w_sum;
   logic [BPS-1:0] w_sym_nxt;
   logic [BPS-1:0] w_k;

   assign w_full       = (r_n == N_FULL);
   assign s_in.x_ready = ~w_full;
   assign w_xfer       = s_in.x_valid & ~w_full;
   assign w_boundary   = (r_ph == PH_LAST) && (r_cyc == CYC_LAST);
   assign w_load       = w_boundary & w_full;

   // y is registered but must show the new symbol at ph=0 right after the
   // boundary, so the carrier is evaluated on next-state values.
   assign w_ph_nxt     = r_ph + PW'(1);
   assign w_sym_nxt    = w_load ? r_col : r_sym;
   assign w_active_nxt = w_boundary ? w_full : r_active;
   assign w_k          = map_sym(w_sym_nxt);
   assign w_off        = PW'(w_k) << (PW - BPS);
   assign w_sum        = w_ph_nxt + w_off;
   assign w_c          = (w_sum < PH_HALF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ph        <= '0;
         r_cyc       <= '0;
         r_col       <= '0;
         r_sym       <= '0;
         r_n         <= '0;
         r_active    <= 1'b0;
         r_y         <= 1'b0;
         r_sym_start <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_ph <= w_ph_nxt;
         if (r_ph == PH_LAST)
            r_cyc <= (r_cyc == CYC_LAST) ? '0 : r_cyc + CW'(1);
         if (w_load) begin
            r_n <= '0;
         end else if (w_xfer) begin
            r_col <= BPS'({r_col, s_in.x});
            r_n   <= r_n + NW'(1);
         end
         r_sym       <= w_sym_nxt;
         r_active    <= w_active_nxt;
         r_y         <= w_active_nxt & w_c;
         r_sym_start <= w_load;
         r_underrun  <= w_boundary & ~w_full;
      end
   end

   assign y         = r_y;
   assign sym_start = r_sym_start;
   assign underrun  = r_underrun;
endmodule
